lcm_from_hcf: RTL
=================

Name: lcm_from_hcf

Overview:
- Downstream consumer of the HCF engine. It takes the two operands and the HCF result when the HCF `done` pulses, and computes LCM = (in1 / hcf) * in2.
- Uses a sequential restoring divider followed by a sequential shift-add multiplier.
- Produces a 2N-bit LCM with a one-cycle `done` pulse and an error flag.
- Sits between the HCF engine and the number-theory result consumers.

Parameters:
- N, 8, operand width in bits; must match the HCF engine's N.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low; 0 clears all state immediately.
- hcf_valid  input  1  driven by the HCF `done`; sampled high = accept request.
- in1  input  N  first operand, the same value given to the HCF engine.
- in2  input  N  second operand, the same value given to the HCF engine.
- hcf  input  N  HCF of in1 and in2.
- busy  output  1  high while a computation is in progress (state is not IDLE).
- lcm  output  2N  result; holds its value until the next accept.
- err  output  1  high with `done` when the request is invalid; holds like `lcm`.
- done  output  1  one-cycle pulse when `lcm`/`err` are updated.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0; lcm=0; err=0; done=0; all internal registers=0.
- States: IDLE, DIV, MUL, DONE. `busy`=1 in DIV, MUL and DONE.
- IDLE: on a rising edge with hcf_valid=1, latch in1, in2 and hcf into internal registers.
  - If hcf==0: go to DONE with pending lcm=0, err=1.
  - Else if in1==0 or in2==0: go to DONE with pending lcm=0, err=0.
  - Otherwise: go to DIV, with the bit counter set to N-1.
- hcf_valid is ignored in every state other than IDLE; there is no queueing.
- DIV: restoring division of the latched in1 by hcf, one quotient bit per cycle, MSB first. Remainder register is N+1 bits. Exactly N cycles, then go to MUL.
  - If the final remainder is nonzero (hcf does not divide in1): skip MUL, go to DONE with pending lcm=0, err=1.
- MUL: shift-add multiply of quotient (N bits) by latched in2 (N bits) into a 2N-bit accumulator, one multiplier bit per cycle, LSB first. Exactly N cycles, then go to DONE. The product always fits in 2N bits; no overflow is possible.
- DONE: on entry, update lcm and err from the pending values and assert done=1 for exactly this one cycle. Next edge goes to IDLE. A new request can be accepted on the edge that leaves IDLE, i.e. one cycle after the done pulse at the earliest.
- Latency, normal path: done is high in the cycle following the (2N+1)th rising edge after the accepting edge. For N=8, done rises 17 edges after accept.
- Latency, short path (zero operand, or hcf==0): done rises 1 edge after accept.
- Latency, non-dividing hcf: done rises N+1 edges after accept.
- lcm and err change only on DONE entry or on reset.
- Reset asserted mid-operation: aborts immediately. No done pulse is produced; outputs read reset values.
- Combinational paths: none from inputs to outputs. All outputs are registered.

Test Plan:
- N=8; in1=24, in2=18, hcf=6, one-cycle hcf_valid -> busy=1 next cycle; done rises after 17 edges; lcm=72; err=0.
- Back-to-back requests: (15,25,5) then, after done, (100,10,10) -> lcm=75, then lcm=100. Each done is a single-cycle pulse. lcm=75 holds between the two done pulses.
- in1=255, in2=254, hcf=1 -> lcm=64770 (full 16-bit result); err=0. in1=0, in2=9, hcf=9 -> done after 1 edge; lcm=0; err=0.
- hcf=0 (in1=4, in2=6) -> done after 1 edge, lcm=0, err=1. in1=24, in2=18, hcf=7 -> done after 9 edges, lcm=0, err=1.
- hcf_valid re-pulsed with (9,6,3) while busy on (24,18,6) -> ignored; only one done; lcm=72.
- rst driven low 5 cycles into a (24,18,6) run -> busy, done, lcm, err go to 0 immediately without waiting for a clock. No done pulse follows. After release, a fresh (24,18,6) request produces lcm=72.

Source files
------------

// File: rtl/lcm_from_hcf.sv
// LCM from operands and their HCF: (in1 / hcf) * in2.
// Restoring divider followed by shift-add multiplier.
module lcm_from_hcf #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           hcf_valid,
    input  logic [N-1:0]   in1,
    input  logic [N-1:0]   in2,
    input  logic [N-1:0]   hcf,
    output logic           busy,
    output logic [2*N-1:0] lcm,
    output logic           err,
    output logic           done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_MUL,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [N-1:0]   dvd;
    logic [N-1:0]   hcf_r;
    logic [N:0]     rem;
    logic [N-1:0]   quot;
    logic [2*N-1:0] mcand;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;

    logic [N+1:0]   wide;
    logic           sub_ok;
    logic [N:0]     diff;
    logic [N:0]     rem_nx;
    logic [2*N-1:0] acc_nx;
    logic           last;
    logic           short_go;

    // One restoring-division step: shift in next dividend bit, try subtract
    always_comb begin
        wide   = {rem, dvd[N-1]};
        sub_ok = (wide >= {2'b00, hcf_r});
        diff   = wide[N:0] - {1'b0, hcf_r};
        rem_nx = sub_ok ? diff : wide[N:0];
        acc_nx = quot[0] ? (acc + mcand) : acc;
        last   = (cnt == '0);
        short_go = (hcf == '0) || (in1 == '0) || (in2 == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (hcf_valid) state_nx = short_go ? S_DONE : S_DIV;
            end
            S_DIV: begin
                if (last) state_nx = (rem_nx != '0) ? S_DONE : S_MUL;
            end
            S_MUL: begin
                if (last) state_nx = S_DONE;
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd   <= '0;
            hcf_r <= '0;
            rem   <= '0;
            quot  <= '0;
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            lcm   <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= (state_nx == S_DONE);
            unique case (state)
                S_IDLE: begin
                    if (hcf_valid) begin
                        dvd   <= in1;
                        hcf_r <= hcf;
                        rem   <= '0;
                        quot  <= '0;
                        mcand <= {{N{1'b0}}, in2};
                        acc   <= '0;
                        cnt   <= CNT_TOP;
                        if (short_go) begin
                            lcm <= '0;
                            err <= (hcf == '0);
                        end
                    end
                end
                S_DIV: begin
                    rem  <= rem_nx;
                    dvd  <= {dvd[N-2:0], 1'b0};
                    quot <= {quot[N-2:0], sub_ok};
                    cnt  <= last ? CNT_TOP : cnt - 1'b1;
                    if (last && rem_nx != '0) begin
                        lcm <= '0;
                        err <= 1'b1;
                    end
                end
                S_MUL: begin
                    acc   <= acc_nx;
                    mcand <= {mcand[2*N-2:0], 1'b0};
                    quot  <= {1'b0, quot[N-1:1]};
                    cnt   <= cnt - 1'b1;
                    if (last) begin
                        lcm <= acc_nx;
                        err <= 1'b0;
                    end
                end
                S_DONE: ;
                default: ;
            endcase
        end
    end

endmodule
